can_tx_sched: RTL and testbench

- Transmit scheduler for the CAN node. Holds NUM_MB transmit mailboxes, each with an 11-bit standard ID.
- Waits for bus idle, then hands the highest-priority pending mailbox (lowest ID) to the bit-level transmit engine.
- Handles arbitration loss and error frames, retrying with a per-mailbox error budget.
- Runs in the sample-point domain: one Clock_SP cycle equals one bit time, and Bit_Input is the sampled bus level, the same signal the receive path sees.

---
 rtl/can_pkg.sv | 18 +
 rtl/can_tx_sched_if.sv | 33 +++
 rtl/can_prio_sel.sv | 30 +++
 rtl/can_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_can_tx_sched.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared constants and state encoding for the CAN transmit scheduler.
package can_pkg;

    localparam int unsigned CAN_ID_W          = 11;
    localparam int unsigned CAN_BUS_IDLE_BITS = 11;
    localparam int unsigned CAN_MAX_RETRY     = 3;

    localparam logic BIT_RECESSIVE = 1'b1;
    localparam logic BIT_DOMINANT  = 1'b0;

    typedef enum logic [1:0] {
        StWaitIdle,
        StSelect,
        StStart,
        StActive
    } tx_state_e;

endpackage

// File: rtl/can_tx_sched_if.sv
// Mailbox, transmit-engine and completion signals of the CAN transmit scheduler.
interface can_tx_sched_if #(
    parameter int unsigned NUM_MB = 4,
    parameter int unsigned MB_W   = 2,
    parameter int unsigned ID_W   = can_pkg::CAN_ID_W
);
    logic              Bit_Input;
    logic [NUM_MB-1:0] Mb_Load;
    logic [ID_W-1:0]   Mb_Id;
    logic [NUM_MB-1:0] Mb_Abort;
    logic [NUM_MB-1:0] Mb_Pending;
    logic              Tx_Start;
    logic [ID_W-1:0]   Tx_Id;
    logic [MB_W-1:0]   Tx_Mb;
    logic              Tx_Done;
    logic              Arb_Lost;
    logic              Erro_Flag;
    logic              Done_Valid;
    logic              Abort_Valid;
    logic [MB_W-1:0]   Done_Mb;

    // master: node side (mailbox writer and bit engine); slave: the scheduler
    modport master (
        output Bit_Input, Mb_Load, Mb_Id, Mb_Abort, Tx_Done, Arb_Lost, Erro_Flag,
        input  Mb_Pending, Tx_Start, Tx_Id, Tx_Mb, Done_Valid, Abort_Valid, Done_Mb
    );

    modport slave (
        input  Bit_Input, Mb_Load, Mb_Id, Mb_Abort, Tx_Done, Arb_Lost, Erro_Flag,
        output Mb_Pending, Tx_Start, Tx_Id, Tx_Mb, Done_Valid, Abort_Valid, Done_Mb
    );

endinterface

// File: rtl/can_prio_sel.sv
// Combinational winner pick over pending mailboxes: lowest ID, ties to the lowest index.
module can_prio_sel
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB = 4,
    parameter int unsigned MB_W   = 2,
    parameter int unsigned ID_W   = CAN_ID_W
) (
    input  logic [NUM_MB-1:0]           pending_i,
    input  logic [NUM_MB-1:0][ID_W-1:0] ids_i,
    output logic                        any_pending_o,
    output logic [MB_W-1:0]             win_mb_o,
    output logic [ID_W-1:0]             win_id_o
);

    always_comb begin
        any_pending_o = 1'b0;
        win_mb_o      = '0;
        win_id_o      = '0;
        for (int i = 0; i < int'(NUM_MB); i++) begin
            // strict less-than keeps the lower index on equal IDs
            if (pending_i[i] && (!any_pending_o || (ids_i[i] < win_id_o))) begin
                any_pending_o = 1'b1;
                win_mb_o      = MB_W'(i);
                win_id_o      = ids_i[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: waits for an idle bus, launches the lowest-ID pending mailbox and
// handles arbitration loss, error retries and cancellation of the frame in flight.
module can_tx_sched
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB        = 4,
    parameter int unsigned MB_W          = 2,
    parameter int unsigned ID_W          = CAN_ID_W,
    parameter int unsigned BUS_IDLE_BITS = CAN_BUS_IDLE_BITS,
    parameter int unsigned MAX_RETRY     = CAN_MAX_RETRY,
    parameter int unsigned RETRY_W       = 2
) (
    input logic           Clock_SP,
    input logic           Reset,
    can_tx_sched_if.slave tx_if
);

    localparam int unsigned IDLE_W = $clog2(BUS_IDLE_BITS + 1);

    tx_state_e                      state_q, state_d;
    logic [IDLE_W-1:0]              idle_q, idle_d;
    logic [NUM_MB-1:0]              pend_q, pend_d;
    logic [NUM_MB-1:0][ID_W-1:0]    id_q, id_d;
    logic [NUM_MB-1:0][RETRY_W-1:0] retry_q, retry_d;
    logic [ID_W-1:0]                tx_id_q, tx_id_d;
    logic [MB_W-1:0]                tx_mb_q, tx_mb_d;
    logic [MB_W-1:0]                done_mb_q, done_mb_d;
    logic                           done_q, done_d;
    logic                           abort_q, abort_d;
    logic                           kill_q, kill_d;

    logic            bus_idle;
    logic            in_flight;
    logic            any_pending;
    logic [MB_W-1:0] win_mb;
    logic [ID_W-1:0] win_id;

    assign bus_idle  = (idle_q == IDLE_W'(BUS_IDLE_BITS));
    assign in_flight = (state_q == StStart) || (state_q == StActive);

    can_prio_sel #(
        .NUM_MB (NUM_MB),
        .MB_W   (MB_W),
        .ID_W   (ID_W)
    ) u_prio_sel (
        .pending_i     (pend_q),
        .ids_i         (id_q),
        .any_pending_o (any_pending),
        .win_mb_o      (win_mb),
        .win_id_o      (win_id)
    );

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        pend_d    = pend_q;
        id_d      = id_q;
        retry_d   = retry_q;
        tx_id_d   = tx_id_q;
        tx_mb_d   = tx_mb_q;
        done_mb_d = done_mb_q;
        kill_d    = kill_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        if ((state_q == StStart) || (tx_if.Bit_Input == BIT_DOMINANT)) begin
            idle_d = '0;
        end else if (!bus_idle) begin
            idle_d = idle_q + 1'b1;
        end

        // Descending scan so the lowest-index idle cancel owns Done_Mb.
        for (int i = int'(NUM_MB) - 1; i >= 0; i--) begin
            if (in_flight && (tx_mb_q == MB_W'(i))) begin
                if (tx_if.Mb_Abort[i]) kill_d = 1'b1;
            end else if (tx_if.Mb_Abort[i]) begin
                if (pend_q[i]) begin
                    pend_d[i] = 1'b0;
                    abort_d   = 1'b1;
                    done_mb_d = MB_W'(i);
                end
            end else if (tx_if.Mb_Load[i]) begin
                pend_d[i]  = 1'b1;
                id_d[i]    = tx_if.Mb_Id;
                retry_d[i] = '0;
            end
        end

        // A frame-end report takes the single Done_Mb slot over a coincident idle cancel.
        unique case (state_q)
            StWaitIdle: begin
                if (bus_idle && any_pending) state_d = StSelect;
            end
            StSelect: begin
                tx_id_d = win_id;
                tx_mb_d = win_mb;
                kill_d  = 1'b0;
                state_d = StStart;
            end
            StStart: begin
                state_d = StActive;
            end
            StActive: begin
                if (tx_if.Tx_Done) begin
                    pend_d[tx_mb_q] = 1'b0;
                    done_d          = 1'b1;
                    abort_d         = 1'b0;
                    done_mb_d       = tx_mb_q;
                    state_d         = StWaitIdle;
                end else if (tx_if.Erro_Flag) begin
                    retry_d[tx_mb_q] = retry_q[tx_mb_q] + 1'b1;
                    if (kill_d || (retry_d[tx_mb_q] == RETRY_W'(MAX_RETRY))) begin
                        pend_d[tx_mb_q] = 1'b0;
                        abort_d         = 1'b1;
                        done_mb_d       = tx_mb_q;
                    end
                    state_d = StWaitIdle;
                end else if (tx_if.Arb_Lost) begin
                    if (kill_d) begin
                        pend_d[tx_mb_q] = 1'b0;
                        abort_d         = 1'b1;
                        done_mb_d       = tx_mb_q;
                    end
                    state_d = StWaitIdle;
                end
            end
        endcase
    end

    always_ff @(posedge Clock_SP) begin
        if (Reset) begin
            state_q   <= StWaitIdle;
            idle_q    <= '0;
            pend_q    <= '0;
            id_q      <= '0;
            retry_q   <= '0;
            tx_id_q   <= '0;
            tx_mb_q   <= '0;
            done_mb_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            pend_q    <= pend_d;
            id_q      <= id_d;
            retry_q   <= retry_d;
            tx_id_q   <= tx_id_d;
            tx_mb_q   <= tx_mb_d;
            done_mb_q <= done_mb_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            kill_q    <= kill_d;
        end
    end

    assign tx_if.Mb_Pending  = pend_q;
    assign tx_if.Tx_Start    = (state_q == StStart);
    assign tx_if.Tx_Id       = tx_id_q;
    assign tx_if.Tx_Mb       = tx_mb_q;
    assign tx_if.Done_Valid  = done_q;
    assign tx_if.Abort_Valid = abort_q;
    assign tx_if.Done_Mb     = done_mb_q;

endmodule

// File: tb/tb_can_tx_sched.sv
// Bench for can_tx_sched: directed and randomized mailbox traffic checked against a
// mailbox-level model (pending flags, IDs, retry counts, lowest (ID, index) wins).
module tb_can_tx_sched;
    import can_pkg::*;

    localparam int NMB  = 4;
    localparam int MBW  = 2;
    localparam int IDW  = 11;
    localparam int IDLE = CAN_BUS_IDLE_BITS;
    localparam int MAXR = CAN_MAX_RETRY;

    logic Clock_SP = 1'b0;
    logic Reset    = 1'b1;
    int   errors   = 0;
    int   checks   = 0;

    bit m_pend  [NMB];
    int m_id    [NMB];
    int m_retry [NMB];

    can_tx_sched_if #(.NUM_MB(NMB), .MB_W(MBW), .ID_W(IDW)) tx_if ();

    can_tx_sched #(
        .NUM_MB        (NMB),
        .MB_W          (MBW),
        .ID_W          (IDW),
        .BUS_IDLE_BITS (IDLE),
        .MAX_RETRY     (MAXR),
        .RETRY_W       (2)
    ) dut (
        .Clock_SP (Clock_SP),
        .Reset    (Reset),
        .tx_if    (tx_if)
    );

    always #5 Clock_SP = ~Clock_SP;

    task automatic tick();
        @(posedge Clock_SP);
        #1;
    endtask

    task automatic clear_inputs();
        tx_if.Bit_Input = 1'b1;
        tx_if.Mb_Load   = '0;
        tx_if.Mb_Id     = '0;
        tx_if.Mb_Abort  = '0;
        tx_if.Tx_Done   = 1'b0;
        tx_if.Arb_Lost  = 1'b0;
        tx_if.Erro_Flag = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < NMB; i++) begin
            m_pend[i]  = 1'b0;
            m_id[i]    = 0;
            m_retry[i] = 0;
        end
    endtask

    function automatic logic [NMB-1:0] pend_vec();
        logic [NMB-1:0] v;
        for (int i = 0; i < NMB; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Rank by the single key id*NMB+index; smallest key transmits first.
    function automatic int model_winner();
        int best;
        int best_key;
        best     = -1;
        best_key = 0;
        for (int i = 0; i < NMB; i++) begin
            if (m_pend[i] && (best < 0 || (m_id[i] * NMB + i) < best_key)) begin
                best     = i;
                best_key = m_id[i] * NMB + i;
            end
        end
        return best;
    endfunction

    function automatic bit model_any();
        return model_winner() >= 0;
    endfunction

    task automatic load(input int mb, input int id);
        tx_if.Mb_Id       = IDW'(id);
        tx_if.Mb_Load     = '0;
        tx_if.Mb_Load[mb] = 1'b1;
        tick();
        tx_if.Mb_Load = '0;
        m_pend[mb]    = 1'b1;
        m_id[mb]      = id;
        m_retry[mb]   = 0;
    endtask

    task automatic wait_start(input string name, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (tx_if.Tx_Start === 1'b1) break;
        end
        checks++;
        if (tx_if.Tx_Start !== 1'b1) begin
            errors++;
            $display("FAIL %s start_timeout: Tx_Start=%b after %0d cycles, required 1",
                     name, tx_if.Tx_Start, cyc);
        end
    endtask

    // Wait for the next start and compare the launched mailbox with the model's winner.
    task automatic launch(input string name, output int mb);
        int cyc;
        mb = model_winner();
        wait_start(name, cyc);
        checks++;
        if (tx_if.Tx_Mb !== MBW'(mb) || tx_if.Tx_Id !== IDW'(m_id[mb])) begin
            errors++;
            $display("FAIL %s winner: Tx_Mb=%0d Tx_Id=%h, required Tx_Mb=%0d Tx_Id=%h",
                     name, tx_if.Tx_Mb, tx_if.Tx_Id, mb, m_id[mb]);
        end
    endtask

    // Called in the START cycle; kind 0 = Tx_Done, 1 = Erro_Flag, 2 = Arb_Lost.
    task automatic frame_end(input string name, input int mb, input int kind, input bit kill);
        bit exp_done;
        bit exp_abort;
        tick();
        checks++;
        if (tx_if.Tx_Start !== 1'b0) begin
            errors++;
            $display("FAIL %s start_width: Tx_Start=%b, required 0", name, tx_if.Tx_Start);
        end
        if (kill) begin
            tx_if.Mb_Abort[mb] = 1'b1;
            tick();
            tx_if.Mb_Abort = '0;
            checks++;
            if (tx_if.Abort_Valid !== 1'b0 || tx_if.Mb_Pending[mb] !== 1'b1) begin
                errors++;
                $display("FAIL %s sticky_abort: Abort_Valid=%b Pending=%b, required 0 and 1",
                         name, tx_if.Abort_Valid, tx_if.Mb_Pending[mb]);
            end
        end
        case (kind)
            0:       tx_if.Tx_Done   = 1'b1;
            1:       tx_if.Erro_Flag = 1'b1;
            default: tx_if.Arb_Lost  = 1'b1;
        endcase
        tick();
        tx_if.Tx_Done   = 1'b0;
        tx_if.Erro_Flag = 1'b0;
        tx_if.Arb_Lost  = 1'b0;

        exp_done  = (kind == 0);
        exp_abort = 1'b0;
        if (kind == 0) begin
            m_pend[mb] = 1'b0;
        end else begin
            if (kind == 1) m_retry[mb]++;
            if (kill || (kind == 1 && m_retry[mb] == MAXR)) begin
                m_pend[mb] = 1'b0;
                exp_abort  = 1'b1;
            end
        end

        checks++;
        if (tx_if.Done_Valid !== exp_done || tx_if.Abort_Valid !== exp_abort) begin
            errors++;
            $display("FAIL %s end_pulse: Done_Valid=%b Abort_Valid=%b, required %b %b",
                     name, tx_if.Done_Valid, tx_if.Abort_Valid, exp_done, exp_abort);
        end
        if (exp_done || exp_abort) begin
            checks++;
            if (tx_if.Done_Mb !== MBW'(mb)) begin
                errors++;
                $display("FAIL %s done_mb: Done_Mb=%0d, required %0d", name, tx_if.Done_Mb, mb);
            end
        end
        checks++;
        if (tx_if.Mb_Pending !== pend_vec()) begin
            errors++;
            $display("FAIL %s pending: Mb_Pending=%b, required %b",
                     name, tx_if.Mb_Pending, pend_vec());
        end
        tick();
        checks++;
        if (tx_if.Done_Valid !== 1'b0 || tx_if.Abort_Valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: Done_Valid=%b Abort_Valid=%b, required 0 0",
                     name, tx_if.Done_Valid, tx_if.Abort_Valid);
        end
    endtask

    task automatic test_reset();
        int mb;
        int seen;
        do_reset();
        load(2, 'h5A5);
        launch("reset_launch", mb);
        tick();
        Reset         = 1'b1;
        tx_if.Tx_Done = 1'b1;
        tick();
        checks++;
        if (tx_if.Mb_Pending !== '0 || tx_if.Tx_Start !== 1'b0 || tx_if.Done_Valid !== 1'b0 ||
            tx_if.Abort_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: Pending=%b Start=%b Done=%b Abort=%b, required all 0",
                     tx_if.Mb_Pending, tx_if.Tx_Start, tx_if.Done_Valid, tx_if.Abort_Valid);
        end
        checks++;
        if (tx_if.Tx_Id !== '0 || tx_if.Tx_Mb !== '0 || tx_if.Done_Mb !== '0) begin
            errors++;
            $display("FAIL reset_regs: Tx_Id=%h Tx_Mb=%0d Done_Mb=%0d, required 0 0 0",
                     tx_if.Tx_Id, tx_if.Tx_Mb, tx_if.Done_Mb);
        end
        Reset         = 1'b0;
        tx_if.Tx_Done = 1'b0;
        for (int i = 0; i < NMB; i++) m_pend[i] = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_if.Done_Valid || tx_if.Abort_Valid || tx_if.Tx_Start) seen++;
        end
        checks++;
        if (seen != 0 || tx_if.Mb_Pending !== '0) begin
            errors++;
            $display("FAIL reset_quiet: events=%0d Pending=%b, required 0 events and 0000",
                     seen, tx_if.Mb_Pending);
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        load(2, 'h123);
        wait_start("basic", cyc);
        // The load cycle already sampled the first recessive bit.
        checks++;
        if (cyc != IDLE + 2 - 1) begin
            errors++;
            $display("FAIL basic_latency: start after %0d cycles, required %0d", cyc, IDLE + 1);
        end
        checks++;
        if (tx_if.Tx_Id !== 11'h123 || tx_if.Tx_Mb !== 2'd2) begin
            errors++;
            $display("FAIL basic_id: Tx_Id=%h Tx_Mb=%0d, required 123 2",
                     tx_if.Tx_Id, tx_if.Tx_Mb);
        end
        frame_end("basic_done", 2, 0, 1'b0);
    endtask

    task automatic test_priority();
        int mb;
        do_reset();
        tx_if.Bit_Input = 1'b0;
        load(0, 'h200);
        load(3, 'h050);
        load(1, 'h050);
        tx_if.Bit_Input = 1'b1;
        launch("prio_first", mb);
        checks++;
        if (mb != 1) begin
            errors++;
            $display("FAIL prio_model: model winner=%0d, required 1", mb);
        end
        frame_end("prio_first_end", mb, 0, 1'b0);
        launch("prio_second", mb);
        frame_end("prio_second_end", mb, 0, 1'b0);
        launch("prio_third", mb);
        frame_end("prio_third_end", mb, 0, 1'b0);

        repeat (4) begin
            int frames;
            do_reset();
            tx_if.Bit_Input = 1'b0;
            for (int i = 0; i < NMB; i++) begin
                if (i == 0 || $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 1) load(i, int'($urandom_range(0, 3)));
                    else load(i, int'($urandom_range(0, 2047)));
                end
            end
            tx_if.Bit_Input = 1'b1;
            frames = 0;
            while (model_any() && frames < 12) begin
                launch("prio_rand", mb);
                frame_end("prio_rand_end", mb, int'($urandom_range(0, 2)), 1'b0);
                frames++;
            end
        end
    endtask

    task automatic test_idle_gap();
        repeat (4) begin
            int k;
            int g;
            int cyc;
            bit early;
            k = int'($urandom_range(1, IDLE - 1));
            g = int'($urandom_range(1, 3));
            early = 1'b0;
            do_reset();
            load(0, int'($urandom_range(0, 2047)));
            repeat (k - 1) begin
                tick();
                if (tx_if.Tx_Start) early = 1'b1;
            end
            tx_if.Bit_Input = 1'b0;
            repeat (g) begin
                tick();
                if (tx_if.Tx_Start) early = 1'b1;
            end
            tx_if.Bit_Input = 1'b1;
            wait_start("idle_gap", cyc);
            checks++;
            if (early || cyc != IDLE + 2) begin
                errors++;
                $display("FAIL idle_gap: early=%b start after %0d cycles, required 0 and %0d",
                         early, cyc, IDLE + 2);
            end
        end
    endtask

    task automatic test_arb_lost();
        int mb;
        do_reset();
        load(0, 'h300);
        launch("arb_first", mb);
        tick();
        load(1, 'h100);
        tx_if.Arb_Lost = 1'b1;
        tick();
        tx_if.Arb_Lost = 1'b0;
        checks++;
        if (tx_if.Done_Valid !== 1'b0 || tx_if.Abort_Valid !== 1'b0 ||
            tx_if.Mb_Pending !== pend_vec()) begin
            errors++;
            $display("FAIL arb_lost: Done=%b Abort=%b Pending=%b, required 0 0 %b",
                     tx_if.Done_Valid, tx_if.Abort_Valid, tx_if.Mb_Pending, pend_vec());
        end
        launch("arb_reselect", mb);
        checks++;
        if (tx_if.Tx_Mb !== 2'd1) begin
            errors++;
            $display("FAIL arb_reselect_mb: Tx_Mb=%0d, required 1", tx_if.Tx_Mb);
        end
        frame_end("arb_mb1_end", mb, 0, 1'b0);
        // Mailbox 0 must still have its full error budget.
        for (int r = 1; r <= MAXR; r++) begin
            launch("arb_retry_launch", mb);
            frame_end("arb_retry_err", mb, 1, 1'b0);
        end
    endtask

    task automatic test_error_retry();
        int mb;
        int seen;
        do_reset();
        load(2, int'($urandom_range(0, 2047)));
        for (int r = 1; r <= MAXR; r++) begin
            launch("err_launch", mb);
            frame_end("err_end", mb, 1, 1'b0);
        end
        seen = 0;
        repeat (30) begin
            tick();
            if (tx_if.Tx_Start) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL err_exhausted: %0d starts after abort, required 0", seen);
        end
        load(2, int'($urandom_range(0, 2047)));
        launch("err_reload", mb);
        frame_end("err_reload_end", mb, 1, 1'b0);
        load(2, int'($urandom_range(0, 2047)));
        for (int r = 1; r <= MAXR; r++) begin
            launch("err_relaunch", mb);
            frame_end("err_relaunch_end", mb, 1, 1'b0);
        end
    endtask

    task automatic test_abort_inflight();
        int mb;
        int kinds [3];
        kinds[0] = 1;
        kinds[1] = 0;
        kinds[2] = 2;
        for (int j = 0; j < 3; j++) begin
            do_reset();
            load(0, int'($urandom_range(0, 2047)));
            launch("kill_launch", mb);
            frame_end("kill_end", mb, kinds[j], 1'b1);
        end
        do_reset();
        tx_if.Bit_Input = 1'b0;
        load(3, 'h0AB);
        tx_if.Mb_Abort = 4'b1100;
        tick();
        tx_if.Mb_Abort = '0;
        m_pend[3]      = 1'b0;
        checks++;
        if (tx_if.Abort_Valid !== 1'b1 || tx_if.Done_Mb !== 2'd3 ||
            tx_if.Mb_Pending !== pend_vec()) begin
            errors++;
            $display("FAIL idle_abort: Abort=%b Done_Mb=%0d Pending=%b, required 1 3 %b",
                     tx_if.Abort_Valid, tx_if.Done_Mb, tx_if.Mb_Pending, pend_vec());
        end
        tick();
        checks++;
        if (tx_if.Abort_Valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort_width: Abort_Valid=%b, required 0", tx_if.Abort_Valid);
        end
    endtask

    task automatic test_load_abort_same();
        do_reset();
        tx_if.Bit_Input   = 1'b0;
        tx_if.Mb_Id       = 11'h077;
        tx_if.Mb_Load[1]  = 1'b1;
        tx_if.Mb_Abort[1] = 1'b1;
        tick();
        clear_inputs();
        tx_if.Bit_Input = 1'b0;
        checks++;
        if (tx_if.Mb_Pending !== 4'b0000 || tx_if.Abort_Valid !== 1'b0) begin
            errors++;
            $display("FAIL load_abort_empty: Pending=%b Abort=%b, required 0000 0",
                     tx_if.Mb_Pending, tx_if.Abort_Valid);
        end
        load(1, 'h066);
        tx_if.Mb_Load[1]  = 1'b1;
        tx_if.Mb_Abort[1] = 1'b1;
        tick();
        clear_inputs();
        m_pend[1] = 1'b0;
        checks++;
        if (tx_if.Mb_Pending !== pend_vec() || tx_if.Abort_Valid !== 1'b1 ||
            tx_if.Done_Mb !== 2'd1) begin
            errors++;
            $display("FAIL load_abort_pending: Pending=%b Abort=%b Done_Mb=%0d, required %b 1 1",
                     tx_if.Mb_Pending, tx_if.Abort_Valid, tx_if.Done_Mb, pend_vec());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_priority();
        test_idle_gap();
        test_arb_lost();
        test_error_retry();
        test_abort_inflight();
        test_load_abort_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
